// File: rtl/axi_csr_master_pkg.sv
// Shared types and constants for the AXI CSR configuration master.
// Fixed AXI attributes are exported here so the parent wrapper ties them consistently.
package axi_csr_master_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RESP,
        ST_DRAIN,
        ST_WAIT_REQ
    } csr_state_e;

    localparam int CSR_SPACE_ID_WIDTH  = 8;
    localparam int CSR_TGT_ID_WIDTH    = 6;
    localparam int CSR_OFFSET_WIDTH    = 28;
    localparam int CSR_BASE_ADDR_WIDTH = CSR_SPACE_ID_WIDTH + CSR_TGT_ID_WIDTH + CSR_OFFSET_WIDTH;

    localparam logic [7:0] AXI_LEN        = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_PROT       = 3'b010;
    localparam logic [3:0] AXI_CACHE      = 4'b0000;
    localparam logic [3:0] AXI_QOS        = 4'b0000;
    localparam logic       AXI_LOCK       = 1'b0;

    // awsize uses the full NAP width, arsize only the CSR word width
    function automatic logic [2:0] axi_size_of(input int unsigned width_bits);
        return 3'($clog2(width_bits / 8));
    endfunction

    // Which CSR word lane of the NAP beat a byte address falls into
    function automatic int unsigned lane_of(input logic [CSR_OFFSET_WIDTH-1:0] addr,
                                            input int unsigned axi_bits,
                                            input int unsigned csr_bits);
        int unsigned byte_off;
        byte_off = 32'(addr) % (axi_bits / 8);
        return byte_off / (csr_bits / 8);
    endfunction

endpackage

// File: rtl/csr_lane_mux.sv
// Places a CSR word/byte-enable into its lane of a NAP beat and extracts
// the same lane from a read beat. Purely combinational.
module csr_lane_mux #(
    parameter int AXI_DATA_WIDTH = 256,
    parameter int CSR_WORD_WIDTH = 32,
    parameter int LANE_W         = 3
) (
    input  logic [LANE_W-1:0]           lane,
    input  logic [CSR_WORD_WIDTH-1:0]   wr_word,
    input  logic [CSR_WORD_WIDTH/8-1:0] wr_be,
    input  logic [AXI_DATA_WIDTH-1:0]   rd_beat,
    output logic [AXI_DATA_WIDTH-1:0]   wr_beat,
    output logic [AXI_DATA_WIDTH/8-1:0] wr_strb,
    output logic [CSR_WORD_WIDTH-1:0]   rd_word
);

    localparam int NUM_LANES = AXI_DATA_WIDTH / CSR_WORD_WIDTH;
    localparam int BE_W      = CSR_WORD_WIDTH / 8;

    always_comb begin
        wr_beat = '0;
        wr_strb = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (lane == LANE_W'(i)) begin
                wr_beat[i*CSR_WORD_WIDTH +: CSR_WORD_WIDTH] = wr_word;
                wr_strb[i*BE_W +: BE_W]                     = wr_be;
                rd_word                                     = rd_beat[i*CSR_WORD_WIDTH +: CSR_WORD_WIDTH];
            end
        end
    end

endmodule

// File: rtl/axi_csr_master_gen.sv
// Turns one req/ack CSR access into a single-beat AXI4 write or read toward a
// CSR-enabled NAP, with response error reporting and a timeout that drains safely.
module axi_csr_master_gen
    import axi_csr_master_pkg::*;
#(
    parameter int         CFG_ADDR_WIDTH = 28,
    parameter int         AXI_DATA_WIDTH = 256,
    parameter int         AXI_ADDR_WIDTH = 42,
    parameter int         AXI_ID_WIDTH   = 8,
    parameter int         CSR_WORD_WIDTH = 32,
    parameter logic [7:0] CSR_ADDR_ID    = 8'h20,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                          i_cfg_clk,
    input  logic                          i_cfg_reset,
    input  logic [5:0]                    i_cfg_tgt_id,
    input  logic                          i_cfg_wr_rdn,
    input  logic [CFG_ADDR_WIDTH-1:0]     i_cfg_addr,
    input  logic [CSR_WORD_WIDTH-1:0]     i_cfg_wdata,
    input  logic [CSR_WORD_WIDTH/8-1:0]   i_cfg_be,
    input  logic                          i_cfg_req,
    output logic [CSR_WORD_WIDTH-1:0]     o_cfg_rdata,
    output logic                          o_cfg_ack,
    output logic                          o_cfg_err,
    output logic                          o_cfg_timeout,

    output logic                          o_awvalid,
    input  logic                          i_awready,
    output logic [AXI_ADDR_WIDTH-1:0]     o_awaddr,
    output logic [AXI_ID_WIDTH-1:0]       o_awid,

    output logic                          o_wvalid,
    input  logic                          i_wready,
    output logic [AXI_DATA_WIDTH-1:0]     o_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   o_wstrb,

    input  logic                          i_bvalid,
    input  logic [AXI_ID_WIDTH-1:0]       i_bid,
    input  logic [1:0]                    i_bresp,
    output logic                          o_bready,

    output logic                          o_arvalid,
    input  logic                          i_arready,
    output logic [AXI_ADDR_WIDTH-1:0]     o_araddr,
    output logic [AXI_ID_WIDTH-1:0]       o_arid,

    input  logic                          i_rvalid,
    input  logic [AXI_ID_WIDTH-1:0]       i_rid,
    input  logic [AXI_DATA_WIDTH-1:0]     i_rdata,
    input  logic [1:0]                    i_rresp,
    output logic                          o_rready
);

    localparam int AXI_BYTES_LOG2 = $clog2(AXI_DATA_WIDTH / 8);
    localparam int NUM_LANES      = AXI_DATA_WIDTH / CSR_WORD_WIDTH;
    localparam int LANE_W         = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TIMER_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    csr_state_e state_q, state_d, done_state;

    logic [CSR_TGT_ID_WIDTH-1:0]    cap_tgt;
    logic [CFG_ADDR_WIDTH-1:0]      cap_addr;
    logic [CSR_WORD_WIDTH-1:0]      cap_wdata;
    logic [CSR_WORD_WIDTH/8-1:0]    cap_be;
    logic                           cap_wr;

    logic [TIMER_W-1:0]             timer;
    logic [LANE_W-1:0]              lane;
    logic [CSR_WORD_WIDTH-1:0]      rd_word;
    logic [CSR_BASE_ADDR_WIDTH-1:0] csr_addr;

    logic aw_left, w_left, ar_left, all_accepted;
    logic b_match, r_match, timer_hit;
    logic complete, abort, bump_id;

    assign lane     = LANE_W'(lane_of(CSR_OFFSET_WIDTH'(cap_addr), AXI_DATA_WIDTH, CSR_WORD_WIDTH));
    assign csr_addr = {CSR_ADDR_ID, cap_tgt, CSR_OFFSET_WIDTH'(cap_addr)};
    assign o_araddr = AXI_ADDR_WIDTH'(csr_addr);
    assign o_awaddr = {o_araddr[AXI_ADDR_WIDTH-1:AXI_BYTES_LOG2], {AXI_BYTES_LOG2{1'b0}}};

    csr_lane_mux #(
        .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
        .CSR_WORD_WIDTH (CSR_WORD_WIDTH),
        .LANE_W         (LANE_W)
    ) u_lane_mux (
        .lane    (lane),
        .wr_word (cap_wdata),
        .wr_be   (cap_be),
        .rd_beat (i_rdata),
        .wr_beat (o_wdata),
        .wr_strb (o_wstrb),
        .rd_word (rd_word)
    );

    assign aw_left      = o_awvalid & ~i_awready;
    assign w_left       = o_wvalid  & ~i_wready;
    assign ar_left      = o_arvalid & ~i_arready;
    assign all_accepted = ~(aw_left | w_left | ar_left);
    assign b_match      = o_bready & i_bvalid & (i_bid == o_awid);
    assign r_match      = o_rready & i_rvalid & (i_rid == o_arid);
    assign timer_hit    = (TIMEOUT_CYCLES != 0) && (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign done_state   = i_cfg_req ? ST_WAIT_REQ : ST_IDLE;

    // A timed-out transaction with a valid still pending defers its ID bump
    // until DRAIN completes, so AxID never changes under an asserted valid.
    always_comb begin
        state_d  = state_q;
        complete = 1'b0;
        abort    = 1'b0;
        bump_id  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_cfg_req) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (timer_hit) begin
                    abort   = 1'b1;
                    bump_id = all_accepted;
                    state_d = all_accepted ? done_state : ST_DRAIN;
                end else if (all_accepted) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (cap_wr ? b_match : r_match) begin
                    complete = 1'b1;
                    bump_id  = 1'b1;
                    state_d  = done_state;
                end else if (timer_hit) begin
                    abort   = 1'b1;
                    bump_id = 1'b1;
                    state_d = done_state;
                end
            end
            ST_DRAIN: begin
                if (all_accepted) begin
                    bump_id = 1'b1;
                    state_d = done_state;
                end
            end
            ST_WAIT_REQ: begin
                if (!i_cfg_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_cfg_clk) begin
        if (i_cfg_reset) state_q <= ST_IDLE;
        else             state_q <= state_d;
    end

    always_ff @(posedge i_cfg_clk) begin
        if (i_cfg_reset) begin
            cap_tgt       <= '0;
            cap_addr      <= '0;
            cap_wdata     <= '0;
            cap_be        <= '0;
            cap_wr        <= 1'b0;
            timer         <= '0;
            o_cfg_rdata   <= '0;
            o_cfg_ack     <= 1'b0;
            o_cfg_err     <= 1'b0;
            o_cfg_timeout <= 1'b0;
            o_awvalid     <= 1'b0;
            o_wvalid      <= 1'b0;
            o_bready      <= 1'b0;
            o_arvalid     <= 1'b0;
            o_rready      <= 1'b0;
            o_awid        <= '0;
            o_arid        <= '0;
        end else begin
            o_cfg_ack     <= complete | abort;
            o_cfg_timeout <= abort;
            o_cfg_err     <= abort | (complete & (cap_wr ? (i_bresp != 2'b00) : (i_rresp != 2'b00)));

            if (o_awvalid && i_awready) o_awvalid <= 1'b0;
            if (o_wvalid  && i_wready)  o_wvalid  <= 1'b0;
            if (o_arvalid && i_arready) o_arvalid <= 1'b0;

            if (state_q == ST_IDLE && i_cfg_req) begin
                cap_tgt   <= i_cfg_tgt_id;
                cap_addr  <= i_cfg_addr;
                cap_wdata <= i_cfg_wdata;
                cap_be    <= i_cfg_be;
                cap_wr    <= i_cfg_wr_rdn;
                o_awvalid <= i_cfg_wr_rdn;
                o_wvalid  <= i_cfg_wr_rdn;
                o_bready  <= i_cfg_wr_rdn;
                o_arvalid <= ~i_cfg_wr_rdn;
                o_rready  <= ~i_cfg_wr_rdn;
            end

            if (complete || abort) begin
                o_bready <= 1'b0;
                o_rready <= 1'b0;
            end

            if (complete && !cap_wr) o_cfg_rdata <= rd_word;

            if (bump_id) begin
                if (cap_wr) o_awid <= o_awid + 1'b1;
                else        o_arid <= o_arid + 1'b1;
            end

            if (state_q == ST_IDLE)
                timer <= '0;
            else if ((state_q == ST_ISSUE || state_q == ST_RESP) && !timer_hit)
                timer <= timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_csr_master_gen.sv
// Directed bench for axi_csr_master_gen: each task drives one scenario and
// checks the observed outputs against hand-computed values.
module tb_axi_csr_master_gen;

    localparam int AXI_DW = 256;
    localparam int CSR_W  = 32;
    localparam int ID_W   = 8;
    localparam int AW     = 42;

    logic              clk = 1'b0;
    logic              reset;
    logic [5:0]        cfg_tgt_id;
    logic              cfg_wr_rdn;
    logic [27:0]       cfg_addr;
    logic [CSR_W-1:0]  cfg_wdata;
    logic [3:0]        cfg_be;
    logic              cfg_req;
    logic [CSR_W-1:0]  cfg_rdata;
    logic              cfg_ack, cfg_err, cfg_timeout;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [AW-1:0]     awaddr, araddr;
    logic [ID_W-1:0]   awid, arid, bid, rid;
    logic [AXI_DW-1:0] wdata, rdata;
    logic [31:0]       wstrb;
    logic [1:0]        bresp, rresp;

    int checks    = 0;
    int passes    = 0;
    int ack_count = 0;
    logic [ID_W-1:0] exp_wr_id = '0;
    logic [ID_W-1:0] exp_rd_id = '0;

    axi_csr_master_gen #(.TIMEOUT_CYCLES(16)) dut (
        .i_cfg_clk(clk), .i_cfg_reset(reset), .i_cfg_tgt_id(cfg_tgt_id), .i_cfg_wr_rdn(cfg_wr_rdn),
        .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata), .i_cfg_be(cfg_be), .i_cfg_req(cfg_req),
        .o_cfg_rdata(cfg_rdata), .o_cfg_ack(cfg_ack), .o_cfg_err(cfg_err), .o_cfg_timeout(cfg_timeout),
        .o_awvalid(awvalid), .i_awready(awready), .o_awaddr(awaddr), .o_awid(awid),
        .o_wvalid(wvalid), .i_wready(wready), .o_wdata(wdata), .o_wstrb(wstrb),
        .i_bvalid(bvalid), .i_bid(bid), .i_bresp(bresp), .o_bready(bready),
        .o_arvalid(arvalid), .i_arready(arready), .o_araddr(araddr), .o_arid(arid),
        .i_rvalid(rvalid), .i_rid(rid), .i_rdata(rdata), .i_rresp(rresp), .o_rready(rready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (cfg_ack === 1'b1) ack_count++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_tgt_id = '0; cfg_wr_rdn = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_be = '0; cfg_req = 1'b0;
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        tick(); tick(); tick();
        checks++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) $display("[TB] FAIL reset_valids: got %b expected 00000", {awvalid, wvalid, bready, arvalid, rready}); else passes++;
        checks++; if ({cfg_ack, cfg_err, cfg_timeout} !== 3'b0) $display("[TB] FAIL reset_ack: got %b expected 000", {cfg_ack, cfg_err, cfg_timeout}); else passes++;
        checks++; if (cfg_rdata !== '0) $display("[TB] FAIL reset_rdata: got %h expected 0", cfg_rdata); else passes++;
        checks++; if ({awid, arid} !== 16'h0) $display("[TB] FAIL reset_ids: got %h expected 0000", {awid, arid}); else passes++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_write_basic();
        logic [AW-1:0]     exp_addr;
        logic [AXI_DW-1:0] exp_wdata;
        int acks0;
        exp_addr  = {8'h20, 6'd5, 28'h0};
        exp_wdata = {32'hDEADBEEF, 224'h0};
        acks0     = ack_count;
        cfg_tgt_id = 6'd5; cfg_wr_rdn = 1'b1; cfg_addr = 28'h1C; cfg_wdata = 32'hDEADBEEF; cfg_be = 4'hF;
        awready = 1'b1; wready = 1'b1; cfg_req = 1'b1;
        tick();
        checks++; if ({awvalid, wvalid, bready, arvalid} !== 4'b1110) $display("[TB] FAIL wr_issue_valids: got %b expected 1110", {awvalid, wvalid, bready, arvalid}); else passes++;
        checks++; if (awaddr !== exp_addr) $display("[TB] FAIL wr_awaddr: got %h expected %h", awaddr, exp_addr); else passes++;
        checks++; if (wdata !== exp_wdata) $display("[TB] FAIL wr_wdata: got %h expected %h", wdata, exp_wdata); else passes++;
        checks++; if (wstrb !== 32'hF000_0000) $display("[TB] FAIL wr_wstrb: got %h expected f0000000", wstrb); else passes++;
        checks++; if (awid !== exp_wr_id) $display("[TB] FAIL wr_awid: got %h expected %h", awid, exp_wr_id); else passes++;
        tick();
        awready = 1'b0; wready = 1'b0;
        checks++; if ({awvalid, wvalid, bready} !== 3'b001) $display("[TB] FAIL wr_accept_drop: got %b expected 001", {awvalid, wvalid, bready}); else passes++;
        bvalid = 1'b1; bid = exp_wr_id; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        checks++; if ({cfg_ack, cfg_err, cfg_timeout} !== 3'b100) $display("[TB] FAIL wr_ack: got %b expected 100", {cfg_ack, cfg_err, cfg_timeout}); else passes++;
        cfg_req = 1'b0;
        tick();
        exp_wr_id++;
        checks++; if (cfg_ack !== 1'b0 || ack_count - acks0 != 1) $display("[TB] FAIL wr_single_ack: got ack=%b count=%0d expected ack=0 count=1", cfg_ack, ack_count - acks0); else passes++;
        checks++; if (awid !== exp_wr_id) $display("[TB] FAIL wr_awid_inc: got %h expected %h", awid, exp_wr_id); else passes++;
        tick();
    endtask

    task automatic test_read_basic();
        logic [AW-1:0]     exp_addr;
        logic [AXI_DW-1:0] beat;
        exp_addr = {8'h20, 6'd5, 28'h08};
        beat = {8{32'hA5A5_5A5A}};
        beat[95:64] = 32'h12345678;
        cfg_tgt_id = 6'd5; cfg_wr_rdn = 1'b0; cfg_addr = 28'h08; arready = 1'b1; cfg_req = 1'b1;
        tick();
        checks++; if ({arvalid, rready, awvalid} !== 3'b110) $display("[TB] FAIL rd_issue_valids: got %b expected 110", {arvalid, rready, awvalid}); else passes++;
        checks++; if (araddr !== exp_addr) $display("[TB] FAIL rd_araddr: got %h expected %h", araddr, exp_addr); else passes++;
        tick();
        arready = 1'b0;
        checks++; if ({arvalid, rready} !== 2'b01) $display("[TB] FAIL rd_accept_drop: got %b expected 01", {arvalid, rready}); else passes++;
        rvalid = 1'b1; rid = exp_rd_id; rdata = beat; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        checks++; if ({cfg_ack, cfg_err, cfg_timeout} !== 3'b100) $display("[TB] FAIL rd_ack: got %b expected 100", {cfg_ack, cfg_err, cfg_timeout}); else passes++;
        checks++; if (cfg_rdata !== 32'h12345678) $display("[TB] FAIL rd_data: got %h expected 12345678", cfg_rdata); else passes++;
        checks++; if (rready !== 1'b0) $display("[TB] FAIL rd_rready_drop: got %b expected 0", rready); else passes++;
        cfg_req = 1'b0;
        tick();
        exp_rd_id++;
        checks++; if (arid !== exp_rd_id) $display("[TB] FAIL rd_arid_inc: got %h expected %h", arid, exp_rd_id); else passes++;
        tick();
    endtask

    task automatic test_write_aw_late();
        logic [AXI_DW-1:0] exp_wdata;
        exp_wdata = '0;
        exp_wdata[63:32] = 32'h0BADF00D;
        cfg_tgt_id = 6'd3; cfg_wr_rdn = 1'b1; cfg_addr = 28'h04; cfg_wdata = 32'h0BADF00D; cfg_be = 4'b0101;
        awready = 1'b0; wready = 1'b1; cfg_req = 1'b1;
        tick();
        checks++; if (wstrb !== 32'h0000_0050) $display("[TB] FAIL late_wstrb: got %h expected 00000050", wstrb); else passes++;
        checks++; if (wdata !== exp_wdata) $display("[TB] FAIL late_wdata: got %h expected %h", wdata, exp_wdata); else passes++;
        tick();
        wready = 1'b0;
        checks++; if ({awvalid, wvalid} !== 2'b10) $display("[TB] FAIL late_w_first: got %b expected 10", {awvalid, wvalid}); else passes++;
        cfg_req = 1'b0;
        tick(); tick();
        checks++; if (awvalid !== 1'b1) $display("[TB] FAIL late_aw_held: got %b expected 1", awvalid); else passes++;
        awready = 1'b1;
        tick();
        awready = 1'b0;
        checks++; if ({awvalid, bready} !== 2'b01) $display("[TB] FAIL late_aw_accept: got %b expected 01", {awvalid, bready}); else passes++;
        cfg_req = 1'b1;
        bvalid = 1'b1; bid = 8'd7; bresp = 2'b00;
        tick();
        checks++; if ({cfg_ack, bready} !== 2'b01) $display("[TB] FAIL wrong_bid_ignored: got ack,bready=%b expected 01", {cfg_ack, bready}); else passes++;
        bid = exp_wr_id;
        tick();
        bvalid = 1'b0;
        checks++; if ({cfg_ack, cfg_err} !== 2'b10) $display("[TB] FAIL late_ack: got %b expected 10", {cfg_ack, cfg_err}); else passes++;
        cfg_req = 1'b0;
        tick();
        exp_wr_id++;
        checks++; if (awid !== exp_wr_id) $display("[TB] FAIL late_awid_inc: got %h expected %h", awid, exp_wr_id); else passes++;
        tick();
    endtask

    task automatic test_read_error();
        logic [AXI_DW-1:0] beat;
        beat = '0;
        beat[159:128] = 32'hCAFEF00D;
        cfg_tgt_id = 6'd9; cfg_wr_rdn = 1'b0; cfg_addr = 28'h10; arready = 1'b1; cfg_req = 1'b1;
        tick(); tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = exp_rd_id; rdata = beat; rresp = 2'b10;
        tick();
        rvalid = 1'b0; rresp = 2'b00;
        checks++; if ({cfg_ack, cfg_err, cfg_timeout} !== 3'b110) $display("[TB] FAIL rd_err_flags: got %b expected 110", {cfg_ack, cfg_err, cfg_timeout}); else passes++;
        checks++; if (cfg_rdata !== 32'hCAFEF00D) $display("[TB] FAIL rd_err_data: got %h expected cafef00d", cfg_rdata); else passes++;
        cfg_req = 1'b0;
        tick();
        exp_rd_id++;
        tick();
    endtask

    task automatic test_timeout();
        int c;
        int acks0;
        logic held_ok;
        cfg_tgt_id = 6'd1; cfg_wr_rdn = 1'b0; cfg_addr = 28'h0; arready = 1'b0; cfg_req = 1'b1;
        tick();
        c = 0;
        checks++; if (arvalid !== 1'b1) $display("[TB] FAIL tmo_issue: got %b expected 1", arvalid); else passes++;
        while (cfg_ack !== 1'b1 && c < 60) begin
            tick();
            c++;
        end
        checks++; if (c != 16) $display("[TB] FAIL tmo_latency: got %0d cycles expected 16", c); else passes++;
        checks++; if ({cfg_ack, cfg_err, cfg_timeout} !== 3'b111) $display("[TB] FAIL tmo_flags: got %b expected 111", {cfg_ack, cfg_err, cfg_timeout}); else passes++;
        checks++; if ({arvalid, rready} !== 2'b10) $display("[TB] FAIL tmo_drain_state: got %b expected 10", {arvalid, rready}); else passes++;
        cfg_req = 1'b0;
        held_ok = 1'b1;
        while (c < 40) begin
            tick();
            c++;
            if (arvalid !== 1'b1) held_ok = 1'b0;
        end
        checks++; if (held_ok !== 1'b1) $display("[TB] FAIL tmo_arvalid_held: got %b expected 1", held_ok); else passes++;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        exp_rd_id++;
        checks++; if (arvalid !== 1'b0) $display("[TB] FAIL tmo_drain_done: got %b expected 0", arvalid); else passes++;
        checks++; if (arid !== exp_rd_id) $display("[TB] FAIL tmo_arid_inc: got %h expected %h", arid, exp_rd_id); else passes++;
        acks0 = ack_count;
        rvalid = 1'b1; rid = exp_rd_id - 1'b1; rdata = '1; rresp = 2'b00;
        tick(); tick(); tick();
        rvalid = 1'b0;
        checks++; if (ack_count != acks0) $display("[TB] FAIL tmo_late_r_ignored: got %0d acks expected 0", ack_count - acks0); else passes++;
        tick();
    endtask

    task automatic test_req_held();
        logic [AXI_DW-1:0] beat;
        int acks0;
        logic quiet;
        beat = '0;
        beat[127:96] = 32'h55AA_33CC;
        acks0 = ack_count;
        cfg_tgt_id = 6'd2; cfg_wr_rdn = 1'b0; cfg_addr = 28'h0C; arready = 1'b1; cfg_req = 1'b1;
        tick(); tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = exp_rd_id; rdata = beat;
        tick();
        rvalid = 1'b0;
        checks++; if (cfg_ack !== 1'b1) $display("[TB] FAIL held_first_ack: got %b expected 1", cfg_ack); else passes++;
        quiet = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (arvalid !== 1'b0) quiet = 1'b0;
        end
        exp_rd_id++;
        checks++; if (ack_count - acks0 != 1) $display("[TB] FAIL held_one_ack: got %0d acks expected 1", ack_count - acks0); else passes++;
        checks++; if (quiet !== 1'b1) $display("[TB] FAIL held_no_reissue: got %b expected 1", quiet); else passes++;
        cfg_req = 1'b0;
        tick();
        cfg_req = 1'b1;
        tick();
        checks++; if ({arvalid, arid} !== {1'b1, exp_rd_id}) $display("[TB] FAIL held_reissue: got %b/%h expected 1/%h", arvalid, arid, exp_rd_id); else passes++;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        rvalid = 1'b1; rid = exp_rd_id; rdata = beat;
        tick();
        rvalid = 1'b0;
        checks++; if ({cfg_ack, cfg_rdata} !== {1'b1, 32'h55AA_33CC}) $display("[TB] FAIL held_second_ack: got %b/%h expected 1/55aa33cc", cfg_ack, cfg_rdata); else passes++;
        cfg_req = 1'b0;
        tick();
        exp_rd_id++;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks0;
        acks0 = ack_count;
        cfg_tgt_id = 6'd4; cfg_wr_rdn = 1'b1; cfg_addr = 28'h20; cfg_wdata = 32'h1; cfg_be = 4'h1;
        awready = 1'b0; wready = 1'b0; cfg_req = 1'b1;
        tick(); tick();
        checks++; if ({awvalid, wvalid} !== 2'b11) $display("[TB] FAIL mid_in_flight: got %b expected 11", {awvalid, wvalid}); else passes++;
        reset = 1'b1;
        tick();
        checks++; if ({awvalid, wvalid, bready, cfg_ack, awid} !== 12'h0) $display("[TB] FAIL mid_reset_state: got %h expected 000", {awvalid, wvalid, bready, cfg_ack, awid}); else passes++;
        reset = 1'b0; cfg_req = 1'b0;
        tick(); tick();
        checks++; if (ack_count != acks0) $display("[TB] FAIL mid_no_ack: got %0d acks expected 0", ack_count - acks0); else passes++;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_write_aw_late();
        test_read_error();
        test_timeout();
        test_req_held();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
